// File: rtl/lock_pkg.sv
// Shared definitions for the LR/SC reservation table: defaults, entry layout and
// the granule address-match helper.
package lock_pkg;

  localparam int unsigned DEF_NUM_HARTS  = 2;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_GRAN_BITS  = 2;
  localparam int unsigned DEF_TIMEOUT    = 1023;

  // Widest address the match helper accepts; narrower addresses are zero-extended.
  localparam int unsigned MAX_ADDR_WIDTH = 64;

  typedef logic [MAX_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic                      valid;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } lock_entry_t;

  // Equal in bits [addr_w-1:gran_bits]; everything else is ignored.
  function automatic logic gran_match(input addr_t a, input addr_t b,
                                      input int unsigned addr_w,
                                      input int unsigned gran_bits);
    logic m;
    m = 1'b1;
    for (int unsigned i = 0; i < MAX_ADDR_WIDTH; i++) begin
      if (i >= gran_bits && i < addr_w && a[i] != b[i]) m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/reservation_entry.sv
// One hart's reservation: valid/addr/age with set-over-clear priority and
// timeout-driven expiry.
module reservation_entry
  import lock_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set,
  input  logic [ADDR_WIDTH-1:0] i_set_addr,
  input  logic                  i_clr,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_expire
);

  localparam int unsigned       AGE_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = AGE_W'(TIMEOUT);
  localparam logic [AGE_W-1:0]  AGE_LAST = (TIMEOUT == 0) ? '0 : AGE_W'(TIMEOUT - 1);

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [AGE_W-1:0]      r_age;
  logic                  w_expire;

  assign w_expire = (TIMEOUT != 0) && r_valid && (r_age == AGE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_age   <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_set_addr;
      r_age   <= '0;
    end else if (i_clr || w_expire) begin
      // address is kept on clear; only the valid bit drops
      r_valid <= 1'b0;
      r_age   <= '0;
    end else if (r_valid && r_age != AGE_MAX) begin
      r_age <= r_age + 1'b1;
    end
  end

  assign o_valid  = r_valid;
  assign o_addr   = r_addr;
  assign o_expire = w_expire;

endmodule

// File: rtl/reservation_table.sv
// Per-hart LR reservations with SC arbitration and cross-hart snoop clears;
// SC results are registered one cycle after the request.
module reservation_table
  import lock_pkg::*;
#(
  parameter int unsigned NUM_HARTS  = DEF_NUM_HARTS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned GRAN_BITS  = DEF_GRAN_BITS,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_HARTS-1:0]              lock_valid,
  input  logic [NUM_HARTS*ADDR_WIDTH-1:0]   lock_addr,
  input  logic [NUM_HARTS-1:0]              unlock,
  input  logic [NUM_HARTS-1:0]              sc_valid,
  input  logic [NUM_HARTS*ADDR_WIDTH-1:0]   sc_addr,
  input  logic [NUM_HARTS-1:0]              st_valid,
  input  logic [NUM_HARTS*ADDR_WIDTH-1:0]   st_addr,
  output logic [NUM_HARTS-1:0]              sc_resp_valid,
  output logic [NUM_HARTS-1:0]              sc_success,
  output logic [NUM_HARTS*(ADDR_WIDTH+1)-1:0] lock_entry
);

  logic [NUM_HARTS-1:0]  w_valid;
  logic [NUM_HARTS-1:0]  w_expire;
  logic [NUM_HARTS-1:0]  w_tent;
  logic [NUM_HARTS-1:0]  w_succ;
  logic [NUM_HARTS-1:0]  w_clr;
  logic [ADDR_WIDTH-1:0] w_addr     [NUM_HARTS];
  addr_t                 w_ent_addr [NUM_HARTS];
  addr_t                 w_sc_addr  [NUM_HARTS];
  addr_t                 w_st_addr  [NUM_HARTS];

  logic [NUM_HARTS-1:0]  r_sc_resp_valid;
  logic [NUM_HARTS-1:0]  r_sc_success;

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    reservation_entry #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .TIMEOUT    (TIMEOUT)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .i_set      (lock_valid[g]),
      .i_set_addr (lock_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_clr      (w_clr[g]),
      .o_valid    (w_valid[g]),
      .o_addr     (w_addr[g]),
      .o_expire   (w_expire[g])
    );

    // widen once so every compare goes through the shared helper
    assign w_ent_addr[g] = addr_t'(w_addr[g]);
    assign w_sc_addr[g]  = addr_t'(sc_addr[g*ADDR_WIDTH +: ADDR_WIDTH]);
    assign w_st_addr[g]  = addr_t'(st_addr[g*ADDR_WIDTH +: ADDR_WIDTH]);

    assign lock_entry[g*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)] = {w_valid[g], w_addr[g]};
  end

  always_comb begin
    w_tent = '0;
    w_succ = '0;
    w_clr  = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      w_tent[h] = sc_valid[h] && w_valid[h] &&
                  gran_match(w_sc_addr[h], w_ent_addr[h], ADDR_WIDTH, GRAN_BITS);
    end
    // lowest index wins among tentative SCs to the same granule
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      w_succ[h] = w_tent[h];
      for (int unsigned j = 0; j < h; j++) begin
        if (w_tent[j] && gran_match(w_sc_addr[j], w_sc_addr[h], ADDR_WIDTH, GRAN_BITS))
          w_succ[h] = 1'b0;
      end
    end
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      w_clr[h] = sc_valid[h] || unlock[h];
      for (int unsigned j = 0; j < NUM_HARTS; j++) begin
        if (j != h) begin
          if (w_succ[j] && gran_match(w_sc_addr[j], w_ent_addr[h], ADDR_WIDTH, GRAN_BITS))
            w_clr[h] = 1'b1;
          if (st_valid[j] && gran_match(w_st_addr[j], w_ent_addr[h], ADDR_WIDTH, GRAN_BITS))
            w_clr[h] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc_resp_valid <= '0;
      r_sc_success    <= '0;
    end else begin
      r_sc_resp_valid <= sc_valid;
      r_sc_success    <= w_succ;
    end
  end

  assign sc_resp_valid = r_sc_resp_valid;
  assign sc_success    = r_sc_success;

endmodule

// File: tb/tb_reservation_table.sv
// Bench for reservation_table: directed scenarios then random traffic, all
// checked against a cycle-level reference model of the reservation rules.
module tb_reservation_table;

  localparam int NH = 2;
  localparam int AW = 32;
  localparam int GB = 2;
  localparam int TO = 4;
  localparam int EW = AW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NH-1:0]     lock_valid, unlock, sc_valid, st_valid;
  logic [NH*AW-1:0]  lock_addr, sc_addr, st_addr;
  logic [NH-1:0]     sc_resp_valid, sc_success;
  logic [NH*EW-1:0]  lock_entry;

  int checks   = 0;
  int failures = 0;

  bit            m_valid [NH];
  logic [AW-1:0] m_addr  [NH];
  int            m_age   [NH];
  logic [NH-1:0] m_resp, m_succ;

  always #5 clk = ~clk;

  reservation_table #(
    .NUM_HARTS  (NH),
    .ADDR_WIDTH (AW),
    .GRAN_BITS  (GB),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lock_valid    (lock_valid),
    .lock_addr     (lock_addr),
    .unlock        (unlock),
    .sc_valid      (sc_valid),
    .sc_addr       (sc_addr),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .sc_resp_valid (sc_resp_valid),
    .sc_success    (sc_success),
    .lock_entry    (lock_entry)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit same_gran(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return ((a ^ b) >> GB) == 0;
  endfunction

  task automatic model_step();
    bit tent [NH];
    bit win  [NH];
    bit clr  [NH];
    if (rst) begin
      for (int h = 0; h < NH; h++) begin
        m_valid[h] = 0; m_addr[h] = '0; m_age[h] = 0;
      end
      m_resp = '0; m_succ = '0;
      return;
    end
    for (int h = 0; h < NH; h++)
      tent[h] = sc_valid[h] && m_valid[h] && same_gran(sc_addr[h*AW +: AW], m_addr[h]);
    for (int h = 0; h < NH; h++) begin
      win[h] = tent[h];
      for (int j = 0; j < h; j++)
        if (tent[j] && same_gran(sc_addr[j*AW +: AW], sc_addr[h*AW +: AW])) win[h] = 0;
    end
    for (int h = 0; h < NH; h++) begin
      clr[h] = sc_valid[h] || unlock[h];
      for (int j = 0; j < NH; j++) begin
        if (j == h) continue;
        if (win[j] && same_gran(sc_addr[j*AW +: AW], m_addr[h])) clr[h] = 1;
        if (st_valid[j] && same_gran(st_addr[j*AW +: AW], m_addr[h])) clr[h] = 1;
      end
    end
    for (int h = 0; h < NH; h++) begin
      m_resp[h] = sc_valid[h];
      m_succ[h] = win[h];
      if (lock_valid[h]) begin
        m_valid[h] = 1; m_addr[h] = lock_addr[h*AW +: AW]; m_age[h] = 0;
      end else if (clr[h]) begin
        m_valid[h] = 0;
      end else if (m_valid[h]) begin
        // a reservation lives exactly TO cycles after the lock edge
        m_age[h]++;
        if (m_age[h] >= TO) m_valid[h] = 0;
      end
    end
  endtask

  task automatic idle();
    rst = 0; lock_valid = '0; unlock = '0; sc_valid = '0; st_valid = '0;
    lock_addr = '0; sc_addr = '0; st_addr = '0;
  endtask

  task automatic do_cycle();
    model_step();
    @(posedge clk);
    #1;
    for (int h = 0; h < NH; h++)
      check_eq($sformatf("entry%0d", h), lock_entry[h*EW +: EW], {m_valid[h], m_addr[h]});
    check_eq("resp_valid", sc_resp_valid, m_resp);
    check_eq("sc_success", sc_success, m_succ);
    idle();
  endtask

  task automatic lr(input int h, input logic [AW-1:0] a);
    lock_valid[h] = 1'b1; lock_addr[h*AW +: AW] = a;
  endtask
  task automatic sc(input int h, input logic [AW-1:0] a);
    sc_valid[h] = 1'b1; sc_addr[h*AW +: AW] = a;
  endtask
  task automatic st(input int h, input logic [AW-1:0] a);
    st_valid[h] = 1'b1; st_addr[h*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] pool [4];
    pool[0] = 32'h1000; pool[1] = 32'h1004; pool[2] = 32'h2000; pool[3] = 32'h1008;
    return pool[$urandom_range(0, 3)] | AW'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    rst = 1;
    do_cycle();
    check_eq("rst_lock_entry", lock_entry, '0);
    check_eq("rst_resp", {sc_resp_valid, sc_success}, '0);

    // LR then SC in the same granule
    lr(0, 32'h1000); do_cycle();
    check_eq("lr_h0", lock_entry[EW-1:0], {1'b1, 32'h1000});
    sc(0, 32'h1002); do_cycle();
    check_eq("sc_h0_resp", {sc_resp_valid[0], sc_success[0]}, 2'b11);
    check_eq("sc_h0_cleared", lock_entry[EW-1], 1'b0);

    // store from hart 1 kills hart 0's reservation only
    lr(0, 32'h2000); lr(1, 32'h2000); do_cycle();
    st(1, 32'h2000); do_cycle();
    check_eq("st_clears_h0", lock_entry[EW-1], 1'b0);
    check_eq("st_keeps_h1", lock_entry[2*EW-1], 1'b1);

    // simultaneous SCs: lowest hart wins
    lr(0, 32'h3000); lr(1, 32'h3000); do_cycle();
    sc(0, 32'h3000); sc(1, 32'h3000); do_cycle();
    check_eq("dual_sc_success", sc_success, 2'b01);
    check_eq("dual_sc_valids", {lock_entry[2*EW-1], lock_entry[EW-1]}, 2'b00);

    // expiry after TO cycles
    lr(1, 32'h4000); do_cycle();
    check_eq("expire_c1", lock_entry[2*EW-1], 1'b1);
    for (int c = 2; c <= 4; c++) begin
      do_cycle();
      check_eq($sformatf("expire_c%0d", c), lock_entry[2*EW-1], 1'b1);
    end
    do_cycle();
    check_eq("expire_c5", lock_entry[2*EW-1], 1'b0);
    sc(1, 32'h4000); do_cycle();
    check_eq("sc_after_expire", {sc_resp_valid[1], sc_success[1]}, 2'b10);

    // lock wins against a same-cycle store; reset mid-reservation with SC pending
    lr(0, 32'h5000); st(1, 32'h5000); do_cycle();
    check_eq("lock_beats_store", lock_entry[EW-1:0], {1'b1, 32'h5000});
    rst = 1; sc(0, 32'h5000); do_cycle();
    check_eq("mid_rst_entry", lock_entry, '0);
    check_eq("mid_rst_resp", {sc_resp_valid, sc_success}, '0);
    do_cycle();
    check_eq("post_rst_resp", sc_resp_valid, '0);

    for (int n = 0; n < 3000; n++) begin
      for (int h = 0; h < NH; h++) begin
        if ($urandom_range(0, 3) == 0) lr(h, rand_addr());
        if ($urandom_range(0, 3) == 0) sc(h, rand_addr());
        if ($urandom_range(0, 4) == 0) st(h, rand_addr());
        if ($urandom_range(0, 9) == 0) unlock[h] = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) rst = 1;
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
